// File: rtl/c3aibadapt_avmm_rdresp_unpack.sv
// AVMM read-response unpacker: pops NWORDS narrow FIFO words per outstanding read and
// presents them as one wide readdata beat under a valid/ready handshake.
module c3aibadapt_avmm_rdresp_unpack #(
  parameter int DWIDTH = 4,
  parameter int NWORDS = 8,
  parameter int CNTW   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fifo_empty,
  input  logic [DWIDTH-1:0]          fifo_rd_data,
  output logic                       fifo_rd_en,
  input  logic                       rd_issue,
  output logic [DWIDTH*NWORDS-1:0]   rdata,
  output logic                       rdata_valid,
  input  logic                       rdata_ready,
  output logic [CNTW-1:0]            outstanding,
  output logic                       unexp_err,
  output logic                       ovf_err
);

  localparam int OUTW = DWIDTH * NWORDS;
  localparam int IDXW = $clog2(NWORDS);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [OUTW-1:0]   rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              unexp_q, unexp_d;
  logic              ovf_q, ovf_d;
  logic              handshake;

  assign handshake = valid_q & rdata_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    unexp_d    = unexp_q;
    ovf_d      = ovf_q;
    fifo_rd_en = 1'b0;

    // A new read and a completed beat in the same cycle cancel out.
    if (rd_issue && !handshake) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (handshake && !rd_issue && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNTW'(1);
    end

    case (state_q)
      IDLE: begin
        // With a read pending we move on without popping; otherwise any word is stray.
        if (cnt_q != '0) begin
          state_d = COLLECT;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          unexp_d    = 1'b1;
        end
      end
      COLLECT: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          rdata_d[idx_q*DWIDTH +: DWIDTH] = fifo_rd_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = (cnt_d != '0) ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      rdata_d = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      unexp_d = 1'b0;
      ovf_d   = 1'b0;
    end

    // Never pop while the block is being cleared.
    if (flush || rst) begin
      fifo_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      unexp_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      unexp_q <= unexp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign outstanding = cnt_q;
  assign unexp_err   = unexp_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_c3aibadapt_avmm_rdresp_unpack.sv
// Bench for the read-response unpacker: a FIFO queue drives the DUT and a transaction-level
// model (word list, beat flag, read count) predicts every output.
module tb_c3aibadapt_avmm_rdresp_unpack;

  localparam int DW = 4;
  localparam int NW = 8;
  localparam int CW = 3;
  localparam int OW = DW * NW;
  localparam int MAXOUT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, fifo_empty, rd_issue, rdata_ready;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en, rdata_valid, unexp_err, ovf_err;
  logic [OW-1:0] rdata;
  logic [CW-1:0] outstanding;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] fifoQ[$];
  bit            gateEmpty = 0;

  // Transaction-level expectation: words gathered so far, whether a beat is on offer,
  // whether a pending read has been noticed, the read count and the sticky errors.
  logic [DW-1:0] mWord[NW];
  int            mCount, mOut;
  bit            mValid, mArmed, mUnexp, mOvf;

  always #5 clk = ~clk;

  c3aibadapt_avmm_rdresp_unpack #(.DWIDTH(DW), .NWORDS(NW), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .rd_issue(rd_issue),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .outstanding(outstanding), .unexp_err(unexp_err), .ovf_err(ovf_err)
  );

  function automatic void modelReset();
    for (int i = 0; i < NW; i++) mWord[i] = '0;
    mCount = 0; mOut = 0; mValid = 0; mArmed = 0; mUnexp = 0; mOvf = 0;
  endfunction

  function automatic logic [OW-1:0] modelData();
    logic [OW-1:0] d = '0;
    for (int i = 0; i < NW; i++) d[i*DW +: DW] = mWord[i];
    return d;
  endfunction

  function automatic bit modelRdEn();
    if (rst || flush || mValid || fifo_empty) return 0;
    if (mArmed) return 1;
    return (mOut == 0);
  endfunction

  function automatic void modelStep();
    bit pop = modelRdEn();
    bit hs = mValid && rdata_ready;
    int newOut = mOut;
    if (flush) begin
      modelReset();
      return;
    end
    if (rd_issue && !hs) begin
      if (mOut == MAXOUT) mOvf = 1; else newOut = mOut + 1;
    end else if (hs && !rd_issue) begin
      newOut = mOut - 1;
    end
    if (mValid) begin
      if (hs) begin
        mValid = 0;
        mArmed = (newOut != 0);
      end
    end else if (mArmed) begin
      if (pop) begin
        mWord[mCount] = fifo_rd_data;
        mCount++;
        if (mCount == NW) begin
          mCount = 0;
          mValid = 1;
        end
      end
    end else if (mOut != 0) begin
      mArmed = 1;
    end else if (pop) begin
      mUnexp = 1;
    end
    mOut = newOut;
  endfunction

  function automatic logic [OW-1:0] packFrom(input int start);
    logic [OW-1:0] d = '0;
    for (int i = 0; i < NW; i++) d[i*DW +: DW] = fifoQ[start + i];
    return d;
  endfunction

  task automatic driveFifo();
    fifo_empty   = (fifoQ.size() == 0) || gateEmpty;
    fifo_rd_data = (fifoQ.size() != 0) ? fifoQ[0] : '0;
  endtask

  // Advance one clock: predict, take the edge, retire the popped word, re-present the FIFO.
  task automatic tick();
    bit pop = modelRdEn();
    modelStep();
    @(posedge clk);
    #1;
    if (pop) void'(fifoQ.pop_front());
    driveFifo();
    #1;
  endtask

  task automatic pushRandom(input int n);
    for (int i = 0; i < n; i++) fifoQ.push_back(DW'($urandom_range(0, 15)));
    driveFifo();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; rd_issue = 0; rdata_ready = 0; gateEmpty = 0;
    driveFifo();
    modelReset();
    #2;
    compared++; if (rdata !== '0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    compared++; if (rdata_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", rdata_valid); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL reset_outstanding: got %0d want 0", outstanding); end
    compared++; if ({unexp_err, ovf_err} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_errors: got %b%b want 00", unexp_err, ovf_err); end
    compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    @(posedge clk);
    #1;
    rst = 0;
    driveFifo();
    #1;
  endtask

  task automatic test_single_read();
    int lastPop = -1, validAt = -2, validCnt = 0;
    rdata_ready = 1;
    rd_issue = 1;
    tick();
    rd_issue = 0;
    compared++; if (outstanding !== CW'(1)) begin mismatched++; $display("[TB] FAIL single_issue_count: got %0d want 1", outstanding); end
    for (int i = 1; i <= NW; i++) fifoQ.push_back(DW'(i));
    driveFifo();
    #1;
    for (int c = 0; c < 14; c++) begin
      compared++; if (fifo_rd_en !== modelRdEn()) begin mismatched++; $display("[TB] FAIL single_rd_en c%0d: got %b want %b", c, fifo_rd_en, modelRdEn()); end
      if (modelRdEn()) lastPop = c;
      tick();
      if (rdata_valid) begin
        validCnt++;
        validAt = c;
      end
    end
    compared++; if (rdata !== 32'h87654321) begin mismatched++; $display("[TB] FAIL single_rdata: got %h want 87654321", rdata); end
    compared++; if (validCnt !== 1) begin mismatched++; $display("[TB] FAIL single_valid_cycles: got %0d want 1", validCnt); end
    compared++; if (validAt !== lastPop) begin mismatched++; $display("[TB] FAIL single_valid_latency: valid after edge %0d, last pop at edge %0d", validAt, lastPop); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL single_final_count: got %0d want 0", outstanding); end
    compared++; if (fifoQ.size() !== 0) begin mismatched++; $display("[TB] FAIL single_fifo_drained: %0d words left want 0", fifoQ.size()); end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] beat[2];
    int holdCycles[2];
    int beats = 0, curValid = 0;
    bit hs, afterHs = 0;
    rdata_ready = 0;
    rd_issue = 1;
    tick();
    tick();
    rd_issue = 0;
    pushRandom(2 * NW);
    beat[0] = packFrom(0);
    beat[1] = packFrom(NW);
    holdCycles[0] = 0;
    holdCycles[1] = 0;
    for (int c = 0; c < 80 && beats < 2; c++) begin
      gateEmpty = c[0];
      driveFifo();
      #1;
      compared++; if (fifo_rd_en !== modelRdEn()) begin mismatched++; $display("[TB] FAIL gaps_rd_en c%0d: got %b want %b", c, fifo_rd_en, modelRdEn()); end
      if (afterHs) begin
        compared++; if (fifo_rd_en !== !fifo_empty) begin mismatched++; $display("[TB] FAIL gaps_resume: got %b want %b", fifo_rd_en, !fifo_empty); end
        afterHs = 0;
      end
      if (rdata_valid) begin
        curValid++;
        rdata_ready = (beats == 0) ? (curValid > 5) : 1'b1;
        compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL gaps_hold_no_pop: got %b want 0", fifo_rd_en); end
        compared++; if (rdata !== beat[beats]) begin mismatched++; $display("[TB] FAIL gaps_rdata beat%0d: got %h want %h", beats, rdata, beat[beats]); end
      end
      hs = rdata_valid && rdata_ready;
      tick();
      if (hs) begin
        holdCycles[beats] = curValid;
        beats++;
        curValid = 0;
        afterHs = 1;
        rdata_ready = 0;
      end
    end
    gateEmpty = 0;
    driveFifo();
    #1;
    compared++; if (beats !== 2) begin mismatched++; $display("[TB] FAIL gaps_timeout: got %0d beats want 2", beats); end
    compared++; if (holdCycles[0] !== 6) begin mismatched++; $display("[TB] FAIL gaps_hold_len: got %0d want 6", holdCycles[0]); end
    compared++; if (holdCycles[1] !== 1) begin mismatched++; $display("[TB] FAIL gaps_second_hold: got %0d want 1", holdCycles[1]); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL gaps_final_count: got %0d want 0", outstanding); end
  endtask

  task automatic test_unexpected();
    rdata_ready = 0;
    pushRandom(3);
    for (int c = 0; c < 3; c++) begin
      compared++; if (fifo_rd_en !== 1'b1) begin mismatched++; $display("[TB] FAIL unexp_pop c%0d: got %b want 1", c, fifo_rd_en); end
      tick();
    end
    tick();
    tick();
    compared++; if (unexp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL unexp_sticky: got %b want 1", unexp_err); end
    compared++; if (fifoQ.size() !== 0) begin mismatched++; $display("[TB] FAIL unexp_discard: %0d words left want 0", fifoQ.size()); end
    compared++; if (rdata_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL unexp_valid: got %b want 0", rdata_valid); end
  endtask

  task automatic test_counter_limits();
    bit seen = 0;
    flush = 1;
    tick();
    flush = 0;
    compared++; if (unexp_err !== 1'b0) begin mismatched++; $display("[TB] FAIL limit_flush_unexp: got %b want 0", unexp_err); end
    rd_issue = 1;
    for (int i = 0; i < MAXOUT; i++) tick();
    compared++; if (outstanding !== CW'(MAXOUT) || ovf_err !== 1'b0) begin mismatched++; $display("[TB] FAIL limit_fill: got %0d/%b want %0d/0", outstanding, ovf_err, MAXOUT); end
    tick();
    compared++; if (outstanding !== CW'(MAXOUT) || ovf_err !== 1'b1) begin mismatched++; $display("[TB] FAIL limit_overflow: got %0d/%b want %0d/1", outstanding, ovf_err, MAXOUT); end
    rd_issue = 0;
    rdata_ready = 0;
    pushRandom(NW);
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = rdata_valid;
    end
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL limit_beat_timeout: rdata_valid=%b want 1", rdata_valid); end
    rd_issue = 1;
    rdata_ready = 1;
    tick();
    rd_issue = 0;
    rdata_ready = 0;
    compared++; if (outstanding !== CW'(MAXOUT) || ovf_err !== 1'b1) begin mismatched++; $display("[TB] FAIL limit_issue_with_hs: got %0d/%b want %0d/1", outstanding, ovf_err, MAXOUT); end
  endtask

  task automatic test_flush();
    int pops = 0;
    logic [OW-1:0] expBeat;
    bit seen = 0;
    flush = 1;
    tick();
    flush = 0;
    pushRandom(1);
    tick();
    compared++; if (unexp_err !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_setup_unexp: got %b want 1", unexp_err); end
    rd_issue = 1;
    tick();
    tick();
    rd_issue = 0;
    compared++; if (outstanding !== CW'(2)) begin mismatched++; $display("[TB] FAIL flush_setup_count: got %0d want 2", outstanding); end
    pushRandom(NW);
    for (int c = 0; c < 20 && pops < 4; c++) begin
      if (modelRdEn()) pops++;
      tick();
    end
    flush = 1;
    driveFifo();
    #1;
    compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
    tick();
    flush = 0;
    compared++; if (rdata_valid !== 1'b0 || rdata !== '0) begin mismatched++; $display("[TB] FAIL flush_data: got %b/%h want 0/0", rdata_valid, rdata); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL flush_count: got %0d want 0", outstanding); end
    compared++; if ({unexp_err, ovf_err} !== 2'b00) begin mismatched++; $display("[TB] FAIL flush_errors: got %b%b want 00", unexp_err, ovf_err); end
    fifoQ.delete();
    driveFifo();
    flush = 1;
    rd_issue = 1;
    tick();
    flush = 0;
    rd_issue = 0;
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL flush_beats_issue: got %0d want 0", outstanding); end
    // A fresh read after the flush must assemble from word slot 0.
    rd_issue = 1;
    tick();
    rd_issue = 0;
    pushRandom(NW);
    expBeat = packFrom(0);
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = rdata_valid;
    end
    compared++; if (!seen || rdata !== expBeat) begin mismatched++; $display("[TB] FAIL flush_restart_beat: got %b/%h want 1/%h", seen, rdata, expBeat); end
    rdata_ready = 1;
    tick();
    rdata_ready = 0;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    rd_issue = 1;
    tick();
    rd_issue = 0;
    rdata_ready = 0;
    pushRandom(NW);
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = rdata_valid;
    end
    compared++; if (!seen || outstanding !== CW'(1)) begin mismatched++; $display("[TB] FAIL areset_setup: got %b/%0d want 1/1", seen, outstanding); end
    #3;
    rst = 1;
    #1;
    compared++; if (rdata_valid !== 1'b0 || rdata !== '0) begin mismatched++; $display("[TB] FAIL areset_data: got %b/%h want 0/0", rdata_valid, rdata); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("[TB] FAIL areset_count: got %0d want 0", outstanding); end
    compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_rd_en: got %b want 0", fifo_rd_en); end
    modelReset();
    @(posedge clk);
    #1;
    rst = 0;
    driveFifo();
    #1;
  endtask

  task automatic test_random();
    flush = 1;
    tick();
    flush = 0;
    for (int c = 0; c < 600; c++) begin
      rd_issue    = ($urandom_range(0, 99) < 25);
      rdata_ready = ($urandom_range(0, 99) < 50);
      flush       = ($urandom_range(0, 99) < 2);
      gateEmpty   = ($urandom_range(0, 99) < 30);
      if (fifoQ.size() < 12 && $urandom_range(0, 99) < 45) fifoQ.push_back(DW'($urandom_range(0, 15)));
      driveFifo();
      #1;
      compared++; if (fifo_rd_en !== modelRdEn()) begin mismatched++; $display("[TB] FAIL rand_rd_en c%0d: got %b want %b", c, fifo_rd_en, modelRdEn()); end
      compared++; if (rdata !== modelData()) begin mismatched++; $display("[TB] FAIL rand_rdata c%0d: got %h want %h", c, rdata, modelData()); end
      compared++; if (rdata_valid !== mValid) begin mismatched++; $display("[TB] FAIL rand_valid c%0d: got %b want %b", c, rdata_valid, mValid); end
      compared++; if (outstanding !== CW'(mOut)) begin mismatched++; $display("[TB] FAIL rand_outstanding c%0d: got %0d want %0d", c, outstanding, mOut); end
      compared++; if (unexp_err !== mUnexp || ovf_err !== mOvf) begin mismatched++; $display("[TB] FAIL rand_errors c%0d: got %b%b want %b%b", c, unexp_err, ovf_err, mUnexp, mOvf); end
      tick();
    end
    flush = 0;
    rd_issue = 0;
    gateEmpty = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_unexpected();
    test_counter_limits();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/c3aibadapt_avmm_rdresp_unpack.md
Name: c3aibadapt_avmm_rdresp_unpack

Overview:
- Read-domain consumer of the AVMM read-response FIFO; sits directly downstream of that FIFO's single-word read port.
- Pops NWORDS narrow words per expected response and assembles them into one wide AVMM readdata beat.
- Presents the beat to the AVMM master side with a valid/ready handshake.
- Tracks outstanding reads and flags unexpected or overflowing responses.

Parameters:
- DWIDTH, 4, FIFO word width; must match the FIFO DWIDTH.
- NWORDS, 8, FIFO words per response; power of 2, at least 2.
- CNTW, 3, outstanding-read counter width; max outstanding = 2^CNTW-1.
- OUTW (derived, localparam), DWIDTH*NWORDS, readdata width.

Ports:
- clk  in  1  read-domain clock (same clock as FIFO rd_clk)
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear, active high
- fifo_empty  in  1  FIFO rd_empty
- fifo_rd_data  in  DWIDTH  FIFO rd_data, combinational, valid the same cycle as fifo_rd_en
- fifo_rd_en  out  1  FIFO pop, combinational
- rd_issue  in  1  one-cycle pulse per AVMM read accepted upstream
- rdata  out  OUTW  assembled read data
- rdata_valid  out  1  rdata valid
- rdata_ready  in  1  consumer accepts rdata
- outstanding  out  CNTW  reads issued but not yet completed
- unexp_err  out  1  sticky: data popped with no read outstanding
- ovf_err  out  1  sticky: rd_issue while outstanding at max

Behaviour:
- Reset (rst=1, async) values:
  - state=IDLE, idx=0, rdata=0, rdata_valid=0, outstanding=0, unexp_err=0, ovf_err=0.
  - fifo_rd_en=0 is a combinational consequence of state.
- flush=1 forces the same values on the next clk edge.
  - flush has priority over every other event, including rd_issue and handshakes in the same cycle.
  - fifo_rd_en=0 while flush=1.
- FIFO assumption: the FIFO runs with r_stop_read=1. This block still never asserts fifo_rd_en while fifo_empty=1.
- States:
  - IDLE
    - fifo_rd_en = ~fifo_empty.
    - Any pop discards the data and sets unexp_err.
    - If outstanding!=0 (registered value) -> COLLECT; the discard pop does not happen in that cycle.
  - COLLECT
    - fifo_rd_en = ~fifo_empty.
    - Each pop writes fifo_rd_data into rdata[idx*DWIDTH +: DWIDTH] (first-popped word in the LSBs), then idx increments.
    - Pop with idx==NWORDS-1 -> HOLD, idx wraps to 0, rdata_valid=1 from the next cycle.
    - No pop: hold state and idx.
  - HOLD
    - fifo_rd_en=0; rdata and rdata_valid are stable until accepted.
    - On rdata_valid&rdata_ready: rdata_valid=0 next cycle.
    - Next state is COLLECT if the post-update outstanding != 0, else IDLE.
- Latency:
  - rdata_valid rises one cycle after the last pop.
  - Minimum NWORDS+1 cycles per beat; there is no pop during HOLD.
- Outstanding counter:
  - Increments on rd_issue.
  - Decrements on the handshake (rdata_valid&rdata_ready).
  - Both in the same cycle: unchanged.
  - rd_issue at 2^CNTW-1 with no handshake: counter saturates and ovf_err is set.
- Errors are sticky until rst or flush.
- rdata is not cleared on handshake; it holds the last beat and partial words are overwritten during the next COLLECT.

Test Plan:
- Single read, DWIDTH=4, NWORDS=8: rd_issue once, FIFO supplies 1,2,...,8 back-to-back with rdata_ready=1 -> rdata=32'h87654321, rdata_valid high exactly one cycle, 1 cycle after the 8th pop; outstanding 1->0; state back to IDLE.
- Gaps and backpressure: fifo_empty toggles every other cycle during collection and rdata_ready is held low 5 cycles -> same rdata; rdata_valid held 5+1 cycles; fifo_rd_en=0 throughout HOLD; a second queued read starts COLLECT on the cycle after the handshake.
- Unexpected data: outstanding=0, fifo_empty=0 for 3 cycles -> 3 pops discarded; unexp_err=1 and stays 1; rdata_valid stays 0.
- Counter limits: 7 rd_issue pulses then an 8th (CNTW=3) -> outstanding=7, ovf_err=1; rd_issue coincident with a handshake -> outstanding unchanged.
- Flush mid-collection: flush after 4 pops with 2 outstanding -> next cycle state=IDLE, idx=0, outstanding=0, errors cleared, rdata_valid=0; flush asserted together with rd_issue -> outstanding=0.
- Async reset during HOLD: assert rst between clock edges -> rdata_valid, rdata and outstanding go to 0 immediately with no clk edge; fifo_rd_en=0.
